// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution stage: opcodes, FSM states and default widths.
// The optional iterative multiplier is enabled by defining ALU_MUL_EN.
package alu_exec_unit_pkg;

    localparam int ALU_DATA_W = 13;
    localparam int ALU_REG_AW = 3;
    localparam int MUL_ITERS  = 13;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_WB   = 2'b11
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; only instantiated when ALU_MUL_EN is defined.
// done and product are combinational and valid during the cycle that performs the final iteration.
module alu_multiplier
    import alu_exec_unit_pkg::*;
#(
    parameter int W = ALU_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(MUL_ITERS + 1);

    logic           active_q, active_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] partial_s;

    // Next iteration of the shift-add recurrence.
    always_comb begin
        partial_s = mplier_q[0] ? mcand_q : '0;
        product   = acc_q + partial_s;
        done      = active_q && (cnt_q == CW'(MUL_ITERS - 1));
        active_d  = active_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (active_q) begin
            acc_d    = product;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                active_d = 1'b0;
            end else begin
                active_d = 1'b1;
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution stage with a one-cycle write-back pulse to the register file.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 111; otherwise that opcode writes nothing.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [2:0]        OpCode,
    input  logic [REG_AW-1:0] DestReg,
    input  logic [DATA_W-1:0] RegData2,
    input  logic [DATA_W-1:0] RegData3,
    output logic              Busy,
    output logic [REG_AW-1:0] WriteReg,
    output logic [DATA_W-1:0] ALU_Result,
    output logic              WriteFlag,
    output logic              Carry,
    output logic              Zero
);

`ifdef ALU_MUL_EN
    localparam bit MUL_ENABLED = 1'b1;
`else
    localparam bit MUL_ENABLED = 1'b0;
`endif

    alu_state_e        state_q, state_d;
    alu_op_e           op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [REG_AW-1:0] dest_q, dest_d, wreg_q, wreg_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              busy_q, busy_d, wflag_q, wflag_d, carry_q, carry_d, zero_q, zero_d;
    logic [DATA_W:0]   sum_s, diff_s;
    logic [3:0]        shamt_s;
    logic [DATA_W-1:0] exec_res_s;
    logic              exec_carry_s;
    logic              mul_done_s;

`ifdef ALU_MUL_EN
    logic [2*DATA_W-1:0] mul_product_s;

    alu_multiplier #(.W(DATA_W)) u_mul (
        .clk     (Clock),
        .rst     (Reset),
        .start   (Start && (state_q == ST_IDLE) && (OpCode == OP_MUL)),
        .a       (RegData2),
        .b       (RegData3),
        .done    (mul_done_s),
        .product (mul_product_s)
    );
`else
    assign mul_done_s = 1'b0;
`endif

    // Result and flag of the latched operation.
    always_comb begin
        sum_s        = {1'b0, a_q} + {1'b0, b_q};
        diff_s       = {1'b0, a_q} - {1'b0, b_q};
        shamt_s      = b_q[3:0];
        exec_res_s   = '0;
        exec_carry_s = 1'b0;
        case (op_q)
            OP_ADD: begin
                exec_res_s   = sum_s[DATA_W-1:0];
                exec_carry_s = sum_s[DATA_W];
            end
            OP_SUB: begin
                exec_res_s   = diff_s[DATA_W-1:0];
                exec_carry_s = diff_s[DATA_W];
            end
            OP_AND: exec_res_s = a_q & b_q;
            OP_OR:  exec_res_s = a_q | b_q;
            OP_XOR: exec_res_s = a_q ^ b_q;
            OP_SHL: exec_res_s = (32'(shamt_s) >= DATA_W) ? '0 : (a_q << shamt_s);
            OP_SHR: exec_res_s = (32'(shamt_s) >= DATA_W) ? '0 : (a_q >> shamt_s);
            OP_MUL: begin
`ifdef ALU_MUL_EN
                exec_res_s   = mul_product_s[DATA_W-1:0];
                exec_carry_s = |mul_product_s[2*DATA_W-1:DATA_W];
`else
                exec_res_s   = '0;
`endif
            end
            default: exec_res_s = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; Start outside IDLE is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ((OpCode == OP_MUL) && MUL_ENABLED) ? ST_MUL : ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: operand capture and write-back values, registered below.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        dest_d   = dest_q;
        wreg_d   = wreg_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        wflag_d  = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        if ((state_q == ST_IDLE) && Start) begin
            a_d    = RegData2;
            b_d    = RegData3;
            op_d   = alu_op_e'(OpCode);
            dest_d = DestReg;
        end else begin
            op_d = op_q;
        end
        // Entry into WB: a disabled multiply still walks the FSM but commits nothing.
        if (state_d == ST_WB) begin
            if ((op_q == OP_MUL) && !MUL_ENABLED) begin
                wflag_d = 1'b0;
            end else begin
                wflag_d  = 1'b1;
                wreg_d   = dest_q;
                result_d = exec_res_s;
                carry_d  = exec_carry_s;
                zero_d   = (exec_res_s == '0);
            end
        end else begin
            wflag_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            dest_q   <= '0;
            wreg_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            wflag_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            wreg_q   <= wreg_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            wflag_q  <= wflag_d;
            busy_q   <= busy_d;
        end
    end

    assign Busy       = busy_q;
    assign WriteFlag  = wflag_q;
    assign WriteReg   = wreg_q;
    assign ALU_Result = result_q;
    assign Carry      = carry_q;
    assign Zero       = zero_q;

endmodule
